// File: rtl/booth_seq_divider.sv
// Sequential signed divider: 32/16 radix-2 non-restoring on magnitudes, valid/ready both sides.
// Define DIV_SATURATE_EN to saturate the quotient on overflow; otherwise the quotient wraps.
module booth_seq_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int PW = DIVISOR_W + 2;
  localparam logic [DIVIDEND_W-1:0] ONE_N   = DIVIDEND_W'(1);
  localparam logic [DIVISOR_W-1:0]  ONE_D   = DIVISOR_W'(1);
  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'(2 ** (DIVISOR_W - 1) - 1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(2 ** (DIVISOR_W - 1));

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t                state;
  logic [DIVIDEND_W-1:0] dvd_r;
  logic [DIVISOR_W-1:0]  dvs_r;
  logic [DIVIDEND_W-1:0] q_r;
  logic [DIVISOR_W-1:0]  mag_d;
  logic [PW-1:0]         p_r;
  logic [5:0]            cnt;

  logic                  dvd_neg;
  logic                  q_neg;
  logic                  q_ovf;
  logic [DIVIDEND_W-1:0] abs_dvd;
  logic [DIVISOR_W-1:0]  abs_dvs;
  logic [PW-1:0]         d_ext;
  logic [PW-1:0]         p_shift;
  logic [PW-1:0]         p_step;
  logic [DIVISOR_W-1:0]  rem_mag;
  logic [DIVISOR_W-1:0]  rem_signed;
  logic [DIVISOR_W-1:0]  q_wrap;

  // Unsigned magnitudes: -2^31 negates to 0x80000000, which reads correctly as 2^31.
  assign dvd_neg = dvd_r[DIVIDEND_W-1];
  assign q_neg   = dvd_r[DIVIDEND_W-1] ^ dvs_r[DIVISOR_W-1];
  assign abs_dvd = dvd_neg ? (~dvd_r + ONE_N) : dvd_r;
  assign abs_dvs = dvs_r[DIVISOR_W-1] ? (~dvs_r + ONE_D) : dvs_r;

  assign d_ext   = {2'b00, mag_d};
  assign p_shift = {p_r[PW-2:0], q_r[DIVIDEND_W-1]};
  assign p_step  = p_r[PW-1] ? (p_shift + d_ext) : (p_shift - d_ext);

  // The restored remainder lies in [0, |divisor|), so low-bit arithmetic is exact.
  assign rem_mag    = p_r[PW-1] ? (p_r[DIVISOR_W-1:0] + mag_d) : p_r[DIVISOR_W-1:0];
  assign rem_signed = dvd_neg ? (~rem_mag + ONE_D) : rem_mag;
  assign q_wrap     = q_neg ? (~q_r[DIVISOR_W-1:0] + ONE_D) : q_r[DIVISOR_W-1:0];
  assign q_ovf      = q_neg ? (q_r > NEG_LIM) : (q_r > POS_LIM);

`ifdef DIV_SATURATE_EN
  logic [DIVISOR_W-1:0] q_sat;
  assign q_sat = q_neg ? {1'b1, {(DIVISOR_W-1){1'b0}}} : {1'b0, {(DIVISOR_W-1){1'b1}}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      q_r         <= '0;
      mag_d       <= '0;
      p_r         <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_r    <= dividend;
            dvs_r    <= divisor;
            in_ready <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          q_r   <= abs_dvd;
          mag_d <= abs_dvs;
          p_r   <= '0;
          cnt   <= 6'(DIVIDEND_W - 1);
          // A zero divisor skips the iterations and is published through FIX.
          state <= (dvs_r == '0) ? FIX : ITER;
        end
        ITER: begin
          p_r <= p_step;
          q_r <= {q_r[DIVIDEND_W-2:0], ~p_step[PW-1]};
          if (cnt == 6'd0) state <= FIX;
          else             cnt   <= cnt - 6'd1;
        end
        FIX: begin
          out_valid <= 1'b1;
          state     <= DONE;
          if (dvs_r == '0) begin
            quotient    <= '0;
            remainder   <= dvd_r[DIVISOR_W-1:0];
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else begin
            remainder   <= rem_signed;
            div_by_zero <= 1'b0;
            overflow    <= q_ovf;
`ifdef DIV_SATURATE_EN
            quotient    <= q_ovf ? q_sat : q_wrap;
`else
            quotient    <= q_wrap;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed self-checking bench for booth_seq_divider; expected values are hand-computed.
// Overflow expectations follow DIV_SATURATE_EN when the bench is built with it.
module tb_booth_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

`ifdef DIV_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  booth_seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair at the accept edge, then count cycles until out_valid.
  task automatic startOp(input logic [31:0] a, input logic [15:0] b, output int lat);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] a, input logic [15:0] b,
                               input logic [15:0] eq, input logic [15:0] er,
                               input logic ez, input logic eo, input int elat);
    int lat;
    out_ready = 1'b1;
    startOp(a, b, lat);
    checkOutput({name, ".latency"}, 32'(lat), 32'(elat));
    checkOutput({name, ".q"}, {16'h0, quotient}, {16'h0, eq});
    checkOutput({name, ".r"}, {16'h0, remainder}, {16'h0, er});
    checkOutput({name, ".dbz"}, {31'h0, div_by_zero}, {31'h0, ez});
    checkOutput({name, ".ovf"}, {31'h0, overflow}, {31'h0, eo});
    tick();
    checkOutput({name, ".valid_drop"}, {31'h0, out_valid}, 32'h0);
    checkOutput({name, ".ready_back"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("rst.in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("rst.out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst.q", {16'h0, quotient}, 32'h0);
    checkOutput("rst.r", {16'h0, remainder}, 32'h0);
    checkOutput("rst.dbz", {31'h0, div_by_zero}, 32'h0);
    checkOutput("rst.ovf", {31'h0, overflow}, 32'h0);

    $display("[TB] directed vectors");
    applyStimulus("recover", 32'hFFFF6F78, 16'hFFDB, 16'h03E8, 16'h0000, 1'b0, 1'b0, 34);
    applyStimulus("pp",      32'h00000064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 34);
    applyStimulus("np",      32'hFFFFFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 34);
    applyStimulus("pn",      32'h00000064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 34);
    applyStimulus("nn",      32'hFFFFFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 34);
    applyStimulus("small",   32'h00000007, 16'h0064, 16'h0000, 16'h0007, 1'b0, 1'b0, 34);
    applyStimulus("dbz",     32'h12345678, 16'h0000, 16'h0000, 16'h5678, 1'b1, 1'b0, 2);
    applyStimulus("ovf_big", 32'h00100000, 16'h0001, SAT ? 16'h7FFF : 16'h0000, 16'h0000, 1'b0, 1'b1, 34);
    applyStimulus("ovf_min", 32'h80000000, 16'hFFFF, SAT ? 16'h7FFF : 16'h0000, 16'h0000, 1'b0, 1'b1, 34);
    applyStimulus("qmin",    32'hFFFF8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 34);
    applyStimulus("qmax1",   32'h00008000, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 16'h0000, 1'b0, 1'b1, 34);
    applyStimulus("dmin",    32'h7FFFFFFF, 16'h8000, SAT ? 16'h8000 : 16'h0001, 16'h7FFF, 1'b0, 1'b1, 34);
    applyStimulus("neg1",    32'hFFFF8001, 16'h7FFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 34);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    startOp(32'd1000, 16'd3, lat);
    checkOutput("bp.latency", 32'(lat), 32'd34);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      dividend = 32'd5;
      divisor  = 16'd1;
      tick();
      checkOutput("bp.valid", {31'h0, out_valid}, 32'h1);
      checkOutput("bp.in_ready", {31'h0, in_ready}, 32'h0);
      checkOutput("bp.q", {16'h0, quotient}, 32'h014D);
      checkOutput("bp.r", {16'h0, remainder}, 32'h0001);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp.release_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("bp.release_ready", {31'h0, in_ready}, 32'h1);
    repeat (40) tick();
    checkOutput("bp.no_phantom", {31'h0, out_valid}, 32'h0);

    $display("[TB] reset mid-iteration");
    in_valid = 1'b1;
    dividend = 32'd100;
    divisor  = 16'd7;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    dividend = 32'h12345678;
    divisor  = 16'h0000;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("mid.out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("mid.in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("mid.q", {16'h0, quotient}, 32'h0);
    repeat (30) tick();
    checkOutput("mid.discarded", {31'h0, out_valid}, 32'h0);
    applyStimulus("after_rst", 32'h00000064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
